// File: rtl/phys_regfile_mp.sv
// phys_regfile_mp: multi-ported physical register file with a per-entry ready scoreboard.
// Writes come from NUM_WR writeback ports. Reads on NUM_RD ports are registered and take one cycle.
// Rename allocation clears an entry's ready bit, and a writeback sets it again.
// A sticky flag records any same-cycle collision between writes, or between a write and an alloc.
// Entry 0 always reads as zero and is always ready.
// Optional macro PRF_BYPASS_EN: a read sees writes made on the same clock edge (write-before-read).
// When PRF_BYPASS_EN is undefined, a read sees the state from before that edge (read-before-write).
module phys_regfile_mp #(
  parameter int PHYS_REG_BITS = 6,
  parameter int DATA_W        = 32,
  parameter int NUM_WR        = 5,
  parameter int NUM_RD        = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WR-1:0]               wr_en,
  input  logic [NUM_WR*PHYS_REG_BITS-1:0] wr_idx,
  input  logic [NUM_WR*DATA_W-1:0]        wr_data,
  input  logic [NUM_WR-1:0]               wr_arch_zero,
  input  logic                            alloc_en,
  input  logic [PHYS_REG_BITS-1:0]        alloc_idx,
  input  logic [NUM_RD-1:0]               rd_req,
  input  logic [NUM_RD*PHYS_REG_BITS-1:0] rd_idx,
  input  logic [NUM_RD-1:0]               rd_arch_zero,
  output logic [NUM_RD*DATA_W-1:0]        rd_data,
  output logic [NUM_RD-1:0]               rd_valid,
  output logic [NUM_RD-1:0]               rd_ready,
  output logic [2**PHYS_REG_BITS-1:0]     ready_vec,
  output logic                            wr_conflict
);

  localparam int DEPTH = 2**PHYS_REG_BITS;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         r_ready;
  logic                     r_conflict;

  logic [PHYS_REG_BITS-1:0] w_wr_idx  [NUM_WR];
  logic [DATA_W-1:0]        w_wr_data [NUM_WR];
  logic [DEPTH-1:0]         w_wr_hit;
  logic [DATA_W-1:0]        w_wr_val  [DEPTH];
  logic                     w_alloc_ok;
  logic                     w_conflict;

  genvar gi;

  // Unpack the flat write-port buses into per-port index/data
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_unpack
      assign w_wr_idx[gi]  = wr_idx[gi*PHYS_REG_BITS +: PHYS_REG_BITS];
      assign w_wr_data[gi] = wr_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // An alloc of entry 0 is meaningless; entry 0 stays ready forever
  assign w_alloc_ok = alloc_en && (alloc_idx != '0);

  // Merge the write ports per entry; ascending scan lets the highest port win
  always_comb begin
    w_wr_hit = '0;
    for (int e = 0; e < DEPTH; e++) begin
      w_wr_val[e] = '0;
    end
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k] && (w_wr_idx[k] != '0)) begin
        w_wr_hit[w_wr_idx[k]] = 1'b1;
        w_wr_val[w_wr_idx[k]] = wr_arch_zero[k] ? '0 : w_wr_data[k];
      end
    end
  end

  // Detect two writes to one entry, or a write and an alloc hitting the same entry
  always_comb begin
    w_conflict = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin
      for (int m = k + 1; m < NUM_WR; m++) begin
        if (wr_en[k] && wr_en[m] && (w_wr_idx[k] == w_wr_idx[m]) && (w_wr_idx[k] != '0)) begin
          w_conflict = 1'b1;
        end
      end
      if (w_alloc_ok && wr_en[k] && (w_wr_idx[k] == alloc_idx)) begin
        w_conflict = 1'b1;
      end
    end
  end

  // Entry storage; entry 0 is never written, so it keeps its reset value of zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_mem[e] <= '0;
      end
    end else begin
      for (int e = 1; e < DEPTH; e++) begin
        if (w_wr_hit[e]) begin
          r_mem[e] <= w_wr_val[e];
        end
      end
    end
  end

  // Scoreboard: writeback sets the ready bit, and a later alloc to the same entry overrides it to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= '1;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_wr_hit[e]) begin
          r_ready[e] <= 1'b1;
        end
      end
      if (w_alloc_ok) begin
        r_ready[alloc_idx] <= 1'b0;
      end
    end
  end

  // Sticky collision flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflict <= 1'b0;
    end else if (w_conflict) begin
      r_conflict <= 1'b1;
    end
  end

  assign ready_vec   = r_ready;
  assign wr_conflict = r_conflict;

  // Read ports: one registered stage each; data/ready hold when no request
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [PHYS_REG_BITS-1:0] w_idx;
      logic [DATA_W-1:0]        w_data;
      logic                     w_rdy;
      logic [DATA_W-1:0]        r_data;
      logic                     r_valid;
      logic                     r_rdy;

      assign w_idx = rd_idx[gi*PHYS_REG_BITS +: PHYS_REG_BITS];

      // Select the read source, then apply the zero rule for x0 or entry 0
      always_comb begin
`ifdef PRF_BYPASS_EN
        if (w_wr_hit[w_idx]) begin
          w_data = w_wr_val[w_idx];
          w_rdy  = !(w_alloc_ok && (alloc_idx == w_idx));
        end else begin
          w_data = r_mem[w_idx];
          w_rdy  = r_ready[w_idx];
        end
`else
        w_data = r_mem[w_idx];
        w_rdy  = r_ready[w_idx];
`endif
        if (rd_arch_zero[gi] || (w_idx == '0)) begin
          w_data = '0;
          w_rdy  = 1'b1;
        end
      end

      // Register read results; a reset drops any in-flight read
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
          r_rdy   <= 1'b0;
        end else begin
          r_valid <= rd_req[gi];
          if (rd_req[gi]) begin
            r_data <= w_data;
            r_rdy  <= w_rdy;
          end
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = r_data;
      assign rd_valid[gi]                 = r_valid;
      assign rd_ready[gi]                 = r_rdy;
    end
  endgenerate

endmodule

// File: doc/phys_regfile_mp.md
Name: phys_regfile_mp

Overview:
- Parametrised successor to the fixed five-unit physical register file.
- Provides NUM_WR write ports and NUM_RD read ports over 2**PHYS_REG_BITS entries, each DATA_W wide.
- Adds a per-entry ready scoreboard (cleared by rename allocation, set on writeback), registered 1-cycle reads, and a sticky write-collision flag.
- Sits between rename/dispatch (alloc), the functional-unit issue stages (reads) and the CDB/writeback stage (writes).

Parameters:
- PHYS_REG_BITS, 6, physical index width; depth = 2**PHYS_REG_BITS.
- DATA_W, 32, entry width.
- NUM_WR, 5, write (writeback) port count.
- NUM_RD, 10, read port count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  NUM_WR  per-port write strobe.
- wr_idx  in  NUM_WR*PHYS_REG_BITS  per-port physical destination; port k occupies slice k.
- wr_data  in  NUM_WR*DATA_W  per-port write value.
- wr_arch_zero  in  NUM_WR  per-port flag: architectural rd is x0; store 0 instead of wr_data.
- alloc_en  in  1  rename allocated a physical register this cycle.
- alloc_idx  in  PHYS_REG_BITS  physical register allocated.
- rd_req  in  NUM_RD  per-port read request.
- rd_idx  in  NUM_RD*PHYS_REG_BITS  per-port physical source.
- rd_arch_zero  in  NUM_RD  per-port flag: architectural source is x0; force result 0.
- rd_data  out  NUM_RD*DATA_W  registered read data.
- rd_valid  out  NUM_RD  rd_data slice valid this cycle.
- rd_ready  out  NUM_RD  registered ready bit of the entry read.
- ready_vec  out  2**PHYS_REG_BITS  live scoreboard, one bit per entry.
- wr_conflict  out  1  sticky collision flag.

Behaviour:
- Reset (async, immediate): all entries 0; ready_vec all 1; rd_data 0; rd_valid 0; rd_ready 0; wr_conflict 0. An in-flight read is dropped. The first edge after rst deasserts behaves as normal operation.
- Entry 0: hardwired to 0 and always ready.
  - Writes with idx 0 are ignored.
  - alloc with idx 0 is ignored.
  - Reads of idx 0 return 0 with rd_ready=1.
- Write, port k, at posedge with wr_en[k] and idx!=0:
  - entry <= wr_arch_zero[k] ? 0 : wr_data[k].
  - ready bit <= 1.
- Multiple write ports hitting the same nonzero idx in one cycle:
  - highest-numbered port's data wins;
  - wr_conflict <= 1, and stays 1 until rst.
- Alloc at posedge with alloc_en and alloc_idx!=0: ready bit <= 0.
- Alloc and write hitting the same idx in one cycle:
  - data is written;
  - the ready bit ends at 0 (alloc wins);
  - wr_conflict <= 1.
- Read, port j, when rd_req[j] sampled at edge t:
  - at t+1, rd_valid[j]=1;
  - rd_data[j] = (rd_arch_zero[j] || idx==0) ? 0 : entry value;
  - rd_ready[j] = ready bit (1 when the zero rule applies).
  - Read latency is exactly 1 cycle, with no stalls.
- rd_req[j] low at edge t: rd_valid[j]=0 at t+1; rd_data[j] and rd_ready[j] hold their previous values.
- Read/write ordering in the same cycle depends on PRF_BYPASS_EN (below).
- Reads never modify state. Any number of read ports may address the same entry.
- ready_vec is a direct register output and reflects state after the most recent edge.

Optional Feature:
- Macro: PRF_BYPASS_EN.
- Defined (write-before-read):
  - A read sampled at edge t whose idx matches a write at edge t returns the write value; with several matching writes, the highest port wins; wr_arch_zero forces 0.
  - rd_ready=1, unless a same-cycle alloc of that idx also occurs; then rd_ready=0.
- Undefined (read-before-write): the read returns the entry and ready bit as they were before edge t's updates. The new value is visible to reads sampled at t+1.

Test Plan:
- Reset check: assert rst mid-cycle with rd_req all 1 -> rd_data=0, rd_valid=0, ready_vec all 1 and wr_conflict=0 immediately, without waiting for a clock edge.
- Basic write/read: write port 2 idx 7 data 0xDEADBEEF; next cycle read port 4 idx 7 -> one cycle later rd_data[4]=0xDEADBEEF, rd_valid[4]=1, rd_ready[4]=1.
- Zero rules:
  - write idx 0 data 0x1234 then read idx 0 -> rd_data=0.
  - write idx 9 with wr_arch_zero=1 and data 0x55 -> a read of idx 9 returns 0.
  - read idx 9 with rd_arch_zero=1 -> 0.
- Scoreboard:
  - alloc idx 12 -> ready_vec[12]=0 next cycle; a read of idx 12 gives rd_ready=0.
  - write idx 12 data 0xA5 -> ready_vec[12]=1; a subsequent read gives rd_ready=1 and data 0xA5.
- Collision: ports 0 and 3 both write idx 20, data 0x11 and 0x33 -> entry 20 = 0x33; wr_conflict=1 and stays 1 until rst.
- Same-cycle write and read of idx 30 (old value 0x1, new value 0x2):
  - PRF_BYPASS_EN defined -> rd_data=0x2.
  - undefined -> rd_data=0x1, and a read the next cycle returns 0x2.
